// File: rtl/ram8_arb_pkg.sv
// Shared types and constants for the two-requester RAM8 arbiter.
package ram8_arb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  function automatic logic other_req(input logic req);
    return (req == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/ram8.sv
// Eight-word RAM: combinational read, write on the rising edge when load is set.
module ram8 #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              load,
  input  logic [2:0]        address,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data
);

  logic [DATA_W-1:0] mem [8];

  always_ff @(posedge clk) begin
    if (load) mem[address] <= in_data;
  end

  assign out_data = mem[address];

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; an owning requester excludes the other.
module rr_arbiter2
  import ram8_arb_pkg::*;
(
  input  logic   a_valid,
  input  logic   b_valid,
  input  logic   prio,
  input  state_t state,
  output logic   grant_a,
  output logic   grant_b
);

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      ST_OWN_A: grant_a = a_valid;
      ST_OWN_B: grant_b = b_valid;
      default: begin
        if (a_valid && b_valid) begin
          grant_a = (prio == REQ_A);
          grant_b = (prio == REQ_B);
        end else begin
          grant_a = a_valid;
          grant_b = b_valid;
        end
      end
    endcase
  end

endmodule

// File: rtl/ram8_arbiter.sv
// Shares one RAM8 between requesters A and B with round-robin grant,
// optional lock ownership and a lock watchdog.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_IDLE  | round-robin between A and B using prio
//   ST_OWN_A | A holds the lock; only A may transfer
//   ST_OWN_B | B holds the lock; only B may transfer
module ram8_arbiter
  import ram8_arb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic              a_we_i,
  input  logic              a_lock_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_rsp_valid_o,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic              b_we_i,
  input  logic              b_lock_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              lock_timeout_o
);

  localparam int CNT_W = $clog2(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  state_t            state, state_nxt;
  logic              prio, prio_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              timeout_nxt;

  logic              grant_a, grant_b;
  logic              xfer, gnt_lock, unlocked_xfer;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              ram_load;

  rr_arbiter2 u_arb (
    .a_valid (a_valid_i),
    .b_valid (b_valid_i),
    .prio    (prio),
    .state   (state),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  ram8 #(.DATA_W(DATA_W)) u_ram (
    .clk      (clk_i),
    .load     (ram_load),
    .address  (ram_addr),
    .in_data  (ram_wdata),
    .out_data (ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state          <= ST_IDLE;
      prio           <= REQ_A;
      cnt            <= '0;
      a_rsp_valid_o  <= 1'b0;
      b_rsp_valid_o  <= 1'b0;
      rsp_rdata_o    <= '0;
      lock_timeout_o <= 1'b0;
    end else begin
      state          <= state_nxt;
      prio           <= prio_nxt;
      cnt            <= cnt_nxt;
      a_rsp_valid_o  <= a_ready_o;
      b_rsp_valid_o  <= b_ready_o;
      lock_timeout_o <= timeout_nxt;
      if (xfer) rsp_rdata_o <= ram_rdata;
    end
  end

  always_comb begin
    state_nxt   = state;
    prio_nxt    = prio;
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          if (gnt_lock) begin
            state_nxt = b_ready_o ? ST_OWN_B : ST_OWN_A;
            cnt_nxt   = '0;
          end else begin
            prio_nxt = b_ready_o ? REQ_A : REQ_B;
          end
        end
      end
      ST_OWN_A, ST_OWN_B: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST || unlocked_xfer) begin
          state_nxt = ST_IDLE;
          prio_nxt  = (state == ST_OWN_A) ? other_req(REQ_A) : other_req(REQ_B);
          cnt_nxt   = '0;
          // Only a watchdog release reports a timeout; a voluntary unlock does not.
          timeout_nxt = !unlocked_xfer;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    a_ready_o     = grant_a & rst_n_i;
    b_ready_o     = grant_b & rst_n_i;
    xfer          = a_ready_o | b_ready_o;
    gnt_lock      = b_ready_o ? b_lock_i : a_lock_i;
    unlocked_xfer = xfer & ~gnt_lock;
    ram_addr      = b_ready_o ? b_addr_i : a_addr_i;
    ram_wdata     = b_ready_o ? b_wdata_i : a_wdata_i;
    ram_load      = (a_ready_o & a_we_i) | (b_ready_o & b_we_i);
  end

endmodule
